tap_stream: RTL and testbench

Sequenced, handshaked tap selector for the FIR MAC datapath. The block holds a snapshot of the shift-register tap bus and streams the taps one beat per accepted transfer, tagged with a coefficient index, to the MAC unit. This replaces FSM-driven combinational tap selection. An optional symmetric mode pre-adds mirrored tap pairs, x[k] + x[N-1-k], so a linear-phase filter needs only ceil(N/2) MAC cycles.

---
 rtl/tap_stream.sv | 94 +++++++++
 tb/tb_tap_stream.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/tap_stream.sv
// Handshaked tap streamer: snapshots the FIR tap bus on start and emits one tap (or mirrored pair sum)
// per accepted beat, tagged with its coefficient index.
module tap_stream #(
    parameter  int DATA_WIDTH = 8,
    parameter  int NUM_TAPS   = 8,
    localparam int IDX_W      = $clog2(NUM_TAPS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           sym_mode,
    input  logic [NUM_TAPS*DATA_WIDTH-1:0] taps_in,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_WIDTH:0]            out_data,
    output logic [IDX_W-1:0]               out_index,
    output logic                           out_last,
    output logic                           busy,
    output logic                           done
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [IDX_W-1:0] LAST_N = IDX_W'(NUM_TAPS - 1);
    localparam logic [IDX_W-1:0] LAST_S = IDX_W'((NUM_TAPS + 1) / 2 - 1);

    state_t                                state_q;
    logic [NUM_TAPS-1:0][DATA_WIDTH-1:0]   snap_q;
    logic                                  mode_q;
    logic                                  done_q;
    logic [IDX_W-1:0]                      k_q;
    logic [IDX_W-1:0]                      k_d;
    logic [IDX_W-1:0]                      mirror;
    logic                                  run;
    logic                                  is_last;
    logic signed [DATA_WIDTH:0]            x_lo;
    logic signed [DATA_WIDTH:0]            x_hi;
    logic signed [DATA_WIDTH:0]            beat;

    assign run     = (state_q == RUN);
    assign is_last = (k_q == (mode_q ? LAST_S : LAST_N));
    assign k_d     = k_q + IDX_W'(1);

    // The packed snapshot layout matches the tap bus slot ordering, so it is captured whole.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            snap_q  <= '0;
            mode_q  <= 1'b0;
            k_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        snap_q  <= taps_in;
                        mode_q  <= sym_mode;
                        k_q     <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (out_ready) begin
                        if (is_last) begin
                            k_q     <= '0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            k_q <= k_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // The odd-N middle tap mirrors onto itself and passes through undoubled.
    always_comb begin
        mirror = LAST_N - k_q;
        x_lo   = {snap_q[k_q][DATA_WIDTH-1], snap_q[k_q]};
        x_hi   = {snap_q[mirror][DATA_WIDTH-1], snap_q[mirror]};
        beat   = (mode_q && (k_q != mirror)) ? (x_lo + x_hi) : x_lo;
    end

    assign out_valid = run;
    assign busy      = run;
    assign done      = done_q;
    assign out_data  = run ? beat : '0;
    assign out_index = k_q;
    assign out_last  = run & is_last;

endmodule

// File: tb/tb_tap_stream.sv
// Bench for tap_stream: queue-based beat model checked every cycle on an N=8 instance, plus literal
// expectations on both the N=8 and an odd N=7 instance.
module tb_tap_stream;

    localparam int DW = 8;
    localparam int N  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst = 1'b1;
    logic            start = 1'b0, sym = 1'b0, ready = 1'b0;
    logic [N*DW-1:0] taps = '0;
    logic            ov, ol, ob, odn;
    logic [DW:0]     od;
    logic [2:0]      oi;

    logic            start7 = 1'b0, sym7 = 1'b0, ready7 = 1'b0;
    logic [7*DW-1:0] taps7 = '0;
    logic            ov7, ol7, ob7, dn7;
    logic [DW:0]     od7;
    logic [2:0]      oi7;

    tap_stream #(.DATA_WIDTH(DW), .NUM_TAPS(N)) dut (
        .clk(clk), .rst(rst), .start(start), .sym_mode(sym), .taps_in(taps),
        .out_valid(ov), .out_ready(ready), .out_data(od), .out_index(oi),
        .out_last(ol), .busy(ob), .done(odn)
    );

    tap_stream #(.DATA_WIDTH(DW), .NUM_TAPS(7)) dut7 (
        .clk(clk), .rst(rst), .start(start7), .sym_mode(sym7), .taps_in(taps7),
        .out_valid(ov7), .out_ready(ready7), .out_data(od7), .out_index(oi7),
        .out_last(ol7), .busy(ob7), .done(dn7)
    );

    int checks = 0, failures = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Model: on an honoured start, the whole expected beat list is computed from the tap values.
    int m_beats[$];
    int m_pos;
    bit m_run, m_done;

    function automatic void build(input logic [N*DW-1:0] t, input bit s);
        int x[N];
        m_beats.delete();
        for (int i = 0; i < N; i++) x[i] = int'($signed(t[i*DW +: DW]));
        if (!s) begin
            for (int k = 0; k < N; k++) m_beats.push_back(x[k]);
        end else begin
            for (int k = 0; k < (N + 1) / 2; k++)
                m_beats.push_back((k == N - 1 - k) ? x[k] : x[k] + x[N-1-k]);
        end
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run = 0; m_pos = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (m_run) begin
                if (ready) begin
                    if (m_pos == m_beats.size() - 1) begin
                        m_run = 0; m_done = 1; m_pos = 0;
                    end else m_pos++;
                end
            end else if (start) begin
                build(taps, sym);
                m_run = 1; m_pos = 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("cmp_valid", int'(ov), int'(m_run));
        chk("cmp_busy", int'(ob), int'(m_run));
        chk("cmp_done", int'(odn), int'(m_done));
        chk("cmp_data", int'($signed(od)), m_run ? m_beats[m_pos] : 0);
        chk("cmp_index", int'(oi), m_run ? m_pos : 0);
        chk("cmp_last", int'(ol), int'(m_run && (m_pos == m_beats.size() - 1)));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string nm);
        int c = 0;
        while (!odn && c < 60) begin
            tick();
            c++;
        end
        chk({nm, "_done_seen"}, int'(odn), 1);
    endtask

    initial begin
        int cnt, stall, c;
        int e7[4] = '{-256, -128, 0, 5};

        tick();
        chk("rst_valid", int'(ov), 0);
        chk("rst_data", int'(od), 0);
        chk("rst_busy", int'(ob), 0);
        chk("rst_done", int'(odn), 0);
        tick();
        rst = 1'b0;
        tick();

        // Normal stream, taps 1..8 in slots 0..7
        for (int i = 0; i < N; i++) taps[i*DW +: DW] = DW'(i + 1);
        ready = 1'b1; sym = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("t1_data", int'($signed(od)), k + 1);
            chk("t1_index", int'(oi), k);
            chk("t1_last", int'(ol), int'(k == 7));
            tick();
        end
        chk("t1_done", int'(odn), 1);
        chk("t1_valid_after", int'(ov), 0);
        tick();

        // Symmetric stream, same taps: every pair sums to 9
        sym = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; sym = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("t2_data", int'($signed(od)), 9);
            chk("t2_index", int'(oi), k);
            chk("t2_last", int'(ol), int'(k == 3));
            tick();
        end
        chk("t2_done", int'(odn), 1);
        tick();

        // Backpressure: three stalled cycles on beat 2
        start = 1'b1;
        tick();
        start = 1'b0;
        cnt = 0; stall = 0;
        while (ov && cnt < 40) begin
            cnt++;
            if (oi == 3'd2 && stall < 3) begin
                ready = 1'b0; stall++;
            end else ready = 1'b1;
            tick();
        end
        ready = 1'b1;
        chk("t3_duration", cnt, 11);
        chk("t3_done", int'(odn), 1);
        tick();

        // Ignored start with taps changing mid-stream, then back-to-back start in the done cycle
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        start = 1'b1;
        for (int i = 0; i < N; i++) taps[i*DW +: DW] = DW'(-10 * (i + 1));
        tick();
        start = 1'b0;
        chk("t4_ignored_data", int'($signed(od)), 5);
        wait_done("t4");
        for (int i = 0; i < N; i++) taps[i*DW +: DW] = DW'(-(i + 1));
        sym = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; sym = 1'b0;
        chk("t4_b2b_valid", int'(ov), 1);
        chk("t4_b2b_data", int'($signed(od)), -9);
        chk("t4_b2b_index", int'(oi), 0);
        wait_done("t4b");
        tick();

        // Reset at beat 4 aborts the stream with no done pulse
        for (int i = 0; i < N; i++) taps[i*DW +: DW] = DW'(20 + i);
        start = 1'b1;
        tick();
        start = 1'b0;
        c = 0;
        while (oi != 3'd4 && c < 20) begin
            tick();
            c++;
        end
        chk("t5_reached_beat4", int'(oi), 4);
        rst = 1'b1;
        #1;
        chk("t5_rst_valid", int'(ov), 0);
        chk("t5_rst_data", int'(od), 0);
        chk("t5_rst_index", int'(oi), 0);
        chk("t5_rst_last", int'(ol), 0);
        chk("t5_rst_busy", int'(ob), 0);
        tick();
        rst = 1'b0;
        tick();
        chk("t5_no_done", int'(odn), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t5_fresh_data", int'($signed(od)), 20);
        chk("t5_fresh_index", int'(oi), 0);
        wait_done("t5");
        tick();

        // Odd N=7 symmetric with extremes; slots 0..6 = -128,-128,0,5,0,0,-128
        taps7 = {8'h80, 8'h00, 8'h00, 8'h05, 8'h00, 8'h80, 8'h80};
        ready7 = 1'b1; sym7 = 1'b1; start7 = 1'b1;
        tick();
        start7 = 1'b0; sym7 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("t6_valid", int'(ov7), 1);
            chk("t6_data", int'($signed(od7)), e7[k]);
            chk("t6_index", int'(oi7), k);
            chk("t6_last", int'(ol7), int'(k == 3));
            tick();
        end
        chk("t6_done", int'(dn7), 1);
        chk("t6_busy_after", int'(ob7), 0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
